alu_result_queue: RTL

//  Downstream stage of the 5-bit ALU. Captures each ALU result with its opcode, overflow
//  and illegal-operation flags into a DEPTH-entry FIFO. Hands entries to the consumer

---
 rtl/alu_result_queue.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_result_queue.sv
// ---------------------------------------------------------------------------
// alu_result_queue
//
// Downstream stage of the 5-bit ALU. Every ALU result is captured together
// with its opcode and its overflow/illegal flags into a DEPTH-entry FIFO.
// Entries are handed to a consumer that may stall. Three saturating event
// counters track overflow results, illegal results and dropped inputs.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both 1 in that cycle. The producer side pushes on in_valid && in_ready.
// The consumer side pops on out_valid && out_ready. in_ready depends only on
// queue state (!full), so it is never a function of in_valid. out_valid and
// out_* come only from registered state (!empty and the head entry). There
// is no combinational path from any input to any output. Data on out_* holds
// stable while out_valid && !out_ready.
//
// Parameters
//   DEPTH  FIFO entries. Must be a power of two, >= 2.
//   CNT_W  width of each saturating event counter.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        producer handshake
//   in_opcode, in_result,
//   in_overflow, in_illegal    ALU output bundle
//   out_valid / out_ready      consumer handshake
//   out_opcode, out_result,
//   out_overflow, out_illegal  head entry
//   count                      entries held, 0..DEPTH
//   ovf_cnt, ill_cnt           accepted entries carrying each flag
//   drop_cnt                   cycles in which in_valid met a full queue
//   clr_cnt                    synchronous clear of the three counters
// ---------------------------------------------------------------------------
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_opcode,
    input  logic [4:0]                 in_result,
    input  logic                       in_overflow,
    input  logic                       in_illegal,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_opcode,
    output logic [4:0]                 out_result,
    output logic                       out_overflow,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic [CNT_W-1:0]           ill_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clr_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry layout: {opcode[8:7], illegal[6], overflow[5], result[4:0]}
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [8:0]    head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic            ev);
        if (ev && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // in_ready stays low while full even if a pop happens the same cycle.
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;
    assign drop = in_valid && full;

    // Storage needs no reset: entries are only observed through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_opcode, in_illegal, in_overflow, in_result};
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Clear has priority over a same-cycle event: the event is lost.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            ovf_cnt  <= '0;
            ill_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            ovf_cnt  <= sat_inc(ovf_cnt,  push && in_overflow);
            ill_cnt  <= sat_inc(ill_cnt,  push && in_illegal);
            drop_cnt <= sat_inc(drop_cnt, drop);
        end
    end

    assign head         = mem[rd_ptr];
    assign out_opcode   = head[8:7];
    assign out_illegal  = head[6];
    assign out_overflow = head[5];
    assign out_result   = head[4:0];
    assign count        = count_q;

endmodule
